vector_register_file_sb: RTL and testbench

- Parametrised successor to the per-core vector register file.
- Holds NUM_REGS vector registers, each NUM_LANES x LANE_WIDTH bits.
- Offers NUM_READ_PORTS registered read ports and per-register outstanding-write tracking (scoreboard), replacing the old pair of wrapping written/invalidated counters with one saturating pending counter per register.
- Adds a lane-masked writeback, an issue handshake with back-pressure, sticky error reporting, and a machine-flags register with a halt-and-drain indication.
- Sits between decode/issue (issue, reads) and execute/writeback (writes, flag updates).

---
 rtl/vector_register_file_sb.sv | 150 +++++++++++++++
 tb/tb_vector_register_file_sb.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_register_file_sb.sv
// +----------------------------------------------------------------------------+
// | vector_register_file_sb: vector register file with a per-register pending   |
// | scoreboard, masked writeback, issue back-pressure and halt/drain flags.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module vector_register_file_sb #(
  parameter int                     NUM_REGS       = 32,
  parameter int                     NUM_LANES      = 4,
  parameter int                     LANE_WIDTH     = 64,
  parameter int                     NUM_READ_PORTS = 2,
  parameter int                     CNT_WIDTH      = 4,
  parameter int                     FLAGS_WIDTH    = 64,
  parameter logic [FLAGS_WIDTH-1:0] HALT_MASK      = 64'h1,
  parameter int                     IDX_W          = $clog2(NUM_REGS) + 1
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NUM_READ_PORTS*IDX_W-1:0]            rd_addr,
  output logic [NUM_READ_PORTS*NUM_LANES*LANE_WIDTH-1:0] rd_data,
  output logic [NUM_READ_PORTS-1:0]                  rd_clean,
  input  logic                                       issue_valid,
  input  logic [IDX_W-1:0]                           issue_reg,
  output logic                                       issue_ready,
  input  logic                                       wb_valid,
  input  logic [IDX_W-1:0]                           wb_reg,
  input  logic [NUM_LANES-1:0]                       wb_lane_mask,
  input  logic [NUM_LANES*LANE_WIDTH-1:0]            wb_data,
  input  logic                                       flag_set_valid,
  input  logic [FLAGS_WIDTH-1:0]                     flag_set_bits,
  output logic [FLAGS_WIDTH-1:0]                     flags,
  output logic                                       halted,
  output logic                                       drained,
  output logic                                       err_index,
  output logic                                       err_underflow
);

  localparam int                   DW       = NUM_LANES * LANE_WIDTH;
  localparam int                   AW       = IDX_W - 1;
  localparam logic [IDX_W-1:0]     NREG_C   = IDX_W'(NUM_REGS);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  logic [DW-1:0]                    mem_q  [NUM_REGS];
  logic [DW-1:0]                    mem_d  [NUM_REGS];
  logic [CNT_WIDTH-1:0]             pend_q [NUM_REGS];
  logic [CNT_WIDTH-1:0]             pend_d [NUM_REGS];
  logic [FLAGS_WIDTH-1:0]           flags_q, flags_d;
  logic [NUM_READ_PORTS*DW-1:0]     rd_data_q, rd_data_d;
  logic [NUM_READ_PORTS-1:0]        rd_clean_q, rd_clean_d;
  logic                             err_index_q, err_index_d;
  logic                             err_underflow_q, err_underflow_d;

  logic          issue_in_range, wb_in_range, issue_acc, wb_ok, same_reg;
  logic          underflow_hit, rd_oob, any_pend;
  logic [AW-1:0] issue_idx, wb_idx;

  assign issue_in_range = (issue_reg < NREG_C);
  assign wb_in_range    = (wb_reg < NREG_C);
  assign issue_idx      = issue_reg[AW-1:0];
  assign wb_idx         = wb_reg[AW-1:0];

  assign halted      = |(flags_q & HALT_MASK);
  assign issue_ready = !halted && (!issue_in_range || (pend_q[issue_idx] != CNT_MAX));
  assign issue_acc   = issue_valid && issue_ready && issue_in_range;
  assign wb_ok       = wb_valid && wb_in_range;
  assign same_reg    = (issue_idx == wb_idx);

  always_comb begin
    mem_d         = mem_q;
    pend_d        = pend_q;
    underflow_hit = 1'b0;
    if (wb_ok) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (wb_lane_mask[l]) begin
          mem_d[wb_idx][l*LANE_WIDTH +: LANE_WIDTH] = wb_data[l*LANE_WIDTH +: LANE_WIDTH];
        end
      end
      // A same-cycle accepted issue is counted first, so it cancels the decrement.
      underflow_hit = !(issue_acc && same_reg) && (pend_q[wb_idx] == '0);
    end
    for (int r = 0; r < NUM_REGS; r++) begin
      if (issue_acc && (issue_idx == AW'(r)) && !(wb_ok && (wb_idx == AW'(r)))) begin
        pend_d[r] = pend_q[r] + CNT_WIDTH'(1);
      end else if (wb_ok && (wb_idx == AW'(r)) && !(issue_acc && (issue_idx == AW'(r)))) begin
        if (pend_q[r] != '0) pend_d[r] = pend_q[r] - CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    logic [IDX_W-1:0] ra;
    rd_data_d  = '0;
    rd_clean_d = '0;
    rd_oob     = 1'b0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      ra = rd_addr[p*IDX_W +: IDX_W];
      if (ra < NREG_C) begin
        rd_data_d[p*DW +: DW] = mem_d[ra[AW-1:0]];
        rd_clean_d[p]         = (pend_d[ra[AW-1:0]] == '0);
      end else begin
        rd_oob = 1'b1;
      end
    end
  end

  always_comb begin
    any_pend = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      any_pend = any_pend | (pend_q[r] != '0);
    end
  end

  assign flags_d         = flags_q | (flag_set_valid ? flag_set_bits : '0);
  assign err_index_d     = err_index_q | (issue_valid && !issue_in_range)
                         | (wb_valid && !wb_in_range) | rd_oob;
  assign err_underflow_d = err_underflow_q | underflow_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        mem_q[r]  <= '0;
        pend_q[r] <= '0;
      end
      flags_q         <= '0;
      rd_data_q       <= '0;
      rd_clean_q      <= '1;
      err_index_q     <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      mem_q           <= mem_d;
      pend_q          <= pend_d;
      flags_q         <= flags_d;
      rd_data_q       <= rd_data_d;
      rd_clean_q      <= rd_clean_d;
      err_index_q     <= err_index_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign rd_data       = rd_data_q;
  assign rd_clean      = rd_clean_q;
  assign flags         = flags_q;
  assign drained       = halted && !any_pend;
  assign err_index     = err_index_q;
  assign err_underflow = err_underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_vector_register_file_sb.sv
// +----------------------------------------------------------------------------+
// | tb_vector_register_file_sb: directed bench with a read-result scoreboard.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_vector_register_file_sb;

  localparam int DW    = 256;
  localparam int IDX_W = 6;
  localparam int NP    = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP*IDX_W-1:0] rd_addr;
  logic [NP*DW-1:0]  rd_data;
  logic [NP-1:0]     rd_clean;
  logic              issue_valid;
  logic [IDX_W-1:0]  issue_reg;
  logic              issue_ready;
  logic              wb_valid;
  logic [IDX_W-1:0]  wb_reg;
  logic [3:0]        wb_lane_mask;
  logic [DW-1:0]     wb_data;
  logic              flag_set_valid;
  logic [63:0]       flag_set_bits;
  logic [63:0]       flags;
  logic              halted, drained, err_index, err_underflow;

  vector_register_file_sb dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_clean(rd_clean),
    .issue_valid(issue_valid), .issue_reg(issue_reg), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_lane_mask(wb_lane_mask), .wb_data(wb_data),
    .flag_set_valid(flag_set_valid), .flag_set_bits(flag_set_bits), .flags(flags),
    .halted(halted), .drained(drained), .err_index(err_index), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    int            port;
    logic [DW-1:0] data;
    logic          clean;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_mis = 0;

  function automatic logic [DW-1:0] rep4(input logic [63:0] v);
    return {4{v}};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_rd(input string tag, input int p, input logic [DW-1:0] d, input logic c);
    exp_t e;
    e.tag = tag; e.port = p; e.data = d; e.clean = c;
    sb_q.push_back(e);
  endtask

  task automatic set_rd(input int p, input int idx);
    rd_addr[p*IDX_W +: IDX_W] = IDX_W'(idx);
  endtask

  // Advance one edge, then retire every read expectation queued during that cycle.
  task automatic tick();
    exp_t e;
    int   n;
    @(posedge clk);
    #1;
    n = sb_q.size();
    repeat (n) begin
      e = sb_q.pop_front();
      n_vec++;
      assert (rd_data[e.port*DW +: DW] === e.data && rd_clean[e.port] === e.clean) else begin
        n_mis++;
        $error("FAIL %s port%0d observed data=%h clean=%b expected data=%h clean=%b",
               e.tag, e.port, rd_data[e.port*DW +: DW], rd_clean[e.port], e.data, e.clean);
      end
    end
  endtask

  task automatic idle();
    rd_addr = '0; issue_valid = 0; issue_reg = '0; wb_valid = 0; wb_reg = '0;
    wb_lane_mask = '0; wb_data = '0; flag_set_valid = 0; flag_set_bits = '0;
  endtask

  task automatic wb(input int r, input logic [3:0] m, input logic [DW-1:0] d);
    wb_valid = 1; wb_reg = IDX_W'(r); wb_lane_mask = m; wb_data = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    #1;
    chk("rst_flags", flags, 64'h0);
    chk("rst_ready", 64'(issue_ready), 64'h1);
    chk("rst_halted", 64'(halted), 64'h0);
    chk("rst_drained", 64'(drained), 64'h0);
    chk("rst_err_idx", 64'(err_index), 64'h0);
    chk("rst_err_uf", 64'(err_underflow), 64'h0);

    for (int i = 0; i < 32; i++) begin
      set_rd(0, i); set_rd(1, 31 - i);
      expect_rd("rst_read_p0", 0, '0, 1'b1);
      expect_rd("rst_read_p1", 1, '0, 1'b1);
      tick();
    end
    idle();

    // r5: two issues, then a half-mask writeback and a full writeback.
    issue_valid = 1; issue_reg = 5; tick(); tick(); issue_valid = 0;
    wb(5, 4'b0101, {64'h4444444444444444, 64'h3333333333333333,
                    64'h2222222222222222, 64'h1111111111111111});
    set_rd(0, 5);
    expect_rd("r5_mask0101_bypass", 0, {64'h0, 64'h3333333333333333, 64'h0, 64'h1111111111111111}, 1'b0);
    tick();
    wb_valid = 0;
    expect_rd("r5_mask0101_hold", 0, {64'h0, 64'h3333333333333333, 64'h0, 64'h1111111111111111}, 1'b0);
    tick();
    wb(5, 4'b1111, rep4(64'hFF));
    expect_rd("r5_full_wb", 0, rep4(64'hFF), 1'b1);
    tick();
    idle();

    // r3: drive to saturation.
    for (int i = 0; i < 16; i++) begin
      issue_valid = 1; issue_reg = 3; #1;
      chk("r3_issue_ready", 64'(issue_ready), (i < 15) ? 64'h1 : 64'h0);
      tick();
    end
    // Saturated: issue is refused, so the writeback applies alone (15 -> 14).
    wb(3, 4'b0000, '0); set_rd(0, 3);
    expect_rd("r3_sat_issue_wb", 0, '0, 1'b0);
    tick();
    idle(); issue_reg = 3; #1;
    chk("r3_ready_at_14", 64'(issue_ready), 64'h1);
    // Accepted issue + wb: net zero, stays 14.
    issue_valid = 1; wb(3, 4'b0000, '0); tick();
    idle(); issue_reg = 3; #1;
    chk("r3_ready_net0", 64'(issue_ready), 64'h1);
    issue_valid = 1; tick(); issue_valid = 0; #1;
    chk("r3_ready_at_15", 64'(issue_ready), 64'h0);
    for (int i = 0; i < 15; i++) begin
      wb(3, 4'b0000, '0); set_rd(0, 3);
      expect_rd("r3_drain", 0, '0, (i == 14) ? 1'b1 : 1'b0);
      tick();
    end
    idle();
    chk("r3_no_underflow", 64'(err_underflow), 64'h0);

    // r8: issue+wb from zero is not an underflow.
    issue_valid = 1; issue_reg = 8; wb(8, 4'b1111, rep4(64'h8)); set_rd(1, 8);
    expect_rd("r8_issue_wb", 1, rep4(64'h8), 1'b1);
    tick(); idle();
    chk("r8_no_underflow", 64'(err_underflow), 64'h0);

    // r7: writeback with nothing pending.
    wb(7, 4'b1111, rep4(64'h7)); set_rd(0, 7);
    expect_rd("r7_underflow_data", 0, rep4(64'h7), 1'b1);
    tick(); idle();
    chk("r7_underflow", 64'(err_underflow), 64'h1);
    tick();
    chk("r7_underflow_sticky", 64'(err_underflow), 64'h1);
    chk("err_idx_before", 64'(err_index), 64'h0);

    // Out-of-range writeback (40 aliases r8 in the low bits).
    wb(40, 4'b1111, rep4(64'hDEAD)); tick(); idle();
    chk("wb40_err_index", 64'(err_index), 64'h1);
    set_rd(0, 8);
    expect_rd("wb40_no_write", 0, rep4(64'h8), 1'b1);
    tick();
    idle();

    // Write-first bypass on r2.
    wb(2, 4'b1111, rep4(64'hAB)); set_rd(0, 2); set_rd(1, 2);
    expect_rd("r2_bypass_p0", 0, rep4(64'hAB), 1'b1);
    expect_rd("r2_bypass_p1", 1, rep4(64'hAB), 1'b1);
    tick(); idle();

    // Halt and drain.
    issue_valid = 1; issue_reg = 1; tick(); issue_valid = 0;
    flag_set_valid = 1; flag_set_bits = 64'h1; tick(); flag_set_valid = 0; #1;
    chk("halt_flags", flags, 64'h1);
    chk("halt_halted", 64'(halted), 64'h1);
    chk("halt_ready", 64'(issue_ready), 64'h0);
    chk("halt_not_drained", 64'(drained), 64'h0);
    issue_valid = 1; issue_reg = 9; tick(); issue_valid = 0;
    wb(1, 4'b1111, rep4(64'h1)); set_rd(0, 1);
    expect_rd("halt_wb_r1", 0, rep4(64'h1), 1'b1);
    tick(); idle();
    chk("halt_drained", 64'(drained), 64'h1);
    flag_set_valid = 1; flag_set_bits = 64'h4; tick(); flag_set_valid = 0; #1;
    chk("flags_accum", flags, 64'h5);

    // Reset mid-halt with a writeback in flight.
    reset = 1; wb(4, 4'b1111, rep4(64'h44)); tick();
    reset = 0; idle(); #1;
    chk("rst2_flags", flags, 64'h0);
    chk("rst2_halted", 64'(halted), 64'h0);
    chk("rst2_drained", 64'(drained), 64'h0);
    chk("rst2_ready", 64'(issue_ready), 64'h1);
    chk("rst2_err_uf", 64'(err_underflow), 64'h0);
    chk("rst2_err_idx", 64'(err_index), 64'h0);
    chk("rst2_rd_clean", 64'(rd_clean), 64'h3);
    chk("rst2_rd_data_lo", rd_data[63:0], 64'h0);
    set_rd(0, 4); set_rd(1, 1);
    expect_rd("rst2_r4", 0, '0, 1'b1);
    expect_rd("rst2_r1", 1, '0, 1'b1);
    tick();

    // Out-of-range read.
    set_rd(0, 4); set_rd(1, 33);
    expect_rd("oob_read_p0", 0, '0, 1'b1);
    expect_rd("oob_read_p1", 1, '0, 1'b0);
    tick(); idle();
    chk("oob_err_index", 64'(err_index), 64'h1);
    chk("sb_empty", 64'(sb_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
